// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: PC / IF/ID / ID/EX hold and flush.
// Optional PIPE_CTRL_PERF_EN adds stall_cnt and flush_cnt performance counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal issue; resolves jump > divide > load-use > interrupt
// DIVWAIT | divider busy, whole front end frozen until done or timeout
// IRQ     | one-cycle redirect to IRQ_VEC, captures return address
module pipe_ctrl #(
  parameter int          DIV_TIMEOUT = 64,
  parameter logic [31:0] IRQ_VEC     = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs1_rd,
  input  logic        id_rs2_rd,
  input  logic [31:0] id_pc,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_load,
  input  logic        ex_div,
  input  logic        div_done,
  input  logic        ex_jump,
  input  logic [31:0] ex_jump_addr,
  input  logic        irq_req,
  output logic        pc_hold,
  output logic        if_id_hold,
  output logic        if_id_flush,
  output logic        id_ex_hold,
  output logic        id_ex_flush,
  output logic        jump_o,
  output logic [31:0] jump_addr_o,
  output logic        irq_ack,
  output logic [31:0] epc_o,
  output logic        div_abort
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int CW = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
  localparam logic [CW-1:0] TC = CW'(DIV_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, DIVWAIT, IRQ} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          hazard;
  logic          div_tc;

  assign hazard = ex_load && (ex_rd_addr != 5'd0) &&
                  ((id_rs1_rd && (id_rs1_addr == ex_rd_addr)) ||
                   (id_rs2_rd && (id_rs2_addr == ex_rd_addr)));

  assign div_tc = (cnt == TC);

  // Outputs are forced low while reset is asserted, whatever the inputs do.
  always_comb begin
    pc_hold     = 1'b0;
    if_id_hold  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_hold  = 1'b0;
    id_ex_flush = 1'b0;
    jump_o      = 1'b0;
    jump_addr_o = 32'h0;
    div_abort   = 1'b0;
    if (rstn) begin
      case (state)
        RUN: begin
          if (ex_jump) begin
            jump_o      = 1'b1;
            jump_addr_o = ex_jump_addr;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (!ex_div && hazard) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
        DIVWAIT: begin
          pc_hold    = 1'b1;
          if_id_hold = 1'b1;
          id_ex_hold = 1'b1;
          div_abort  = div_tc && !div_done;
        end
        IRQ: begin
          jump_o      = 1'b1;
          jump_addr_o = IRQ_VEC;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= RUN;
      cnt     <= '0;
      epc_o   <= 32'h0;
      irq_ack <= 1'b0;
    end else begin
      irq_ack <= 1'b0;
      case (state)
        RUN: begin
          // A divide paired with a jump is older than the jump and still completes.
          if (ex_div) begin
            state <= DIVWAIT;
            cnt   <= '0;
          end else if (!ex_jump && !hazard && irq_req) begin
            state   <= IRQ;
            irq_ack <= 1'b1;
          end
        end
        DIVWAIT: begin
          cnt <= cnt + 1'b1;
          if (div_done || div_tc) state <= RUN;
        end
        IRQ: begin
          state <= RUN;
          epc_o <= ex_jump ? ex_jump_addr : id_pc;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= 32'h0;
      flush_cnt <= 32'h0;
    end else begin
      if (pc_hold)     stall_cnt <= stall_cnt + 32'd1;
      if (if_id_flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl: default instance plus a DIV_TIMEOUT=8 instance
// driven by the same inputs.
module tb_pipe_ctrl;

  typedef struct packed {
    logic        pc_hold;
    logic        if_id_hold;
    logic        if_id_flush;
    logic        id_ex_hold;
    logic        id_ex_flush;
    logic        jump;
    logic [31:0] jaddr;
    logic        irq_ack;
    logic [31:0] epc;
    logic        div_abort;
  } vec_t;

  logic        clk, rstn;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_rs1_rd, id_rs2_rd, ex_load, ex_div, div_done, ex_jump, irq_req;
  logic [31:0] id_pc, ex_jump_addr;

  logic        a_pch, a_ifh, a_iff, a_idh, a_idf, a_jmp, a_ack, a_abt;
  logic [31:0] a_jad, a_epc;
  logic        b_pch, b_ifh, b_iff, b_idh, b_idf, b_jmp, b_ack, b_abt;
  logic [31:0] b_jad, b_epc;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] a_sc, a_fc, b_sc, b_fc;
`endif

  vec_t o_a, o_b;
  assign o_a = {a_pch, a_ifh, a_iff, a_idh, a_idf, a_jmp, a_jad, a_ack, a_epc, a_abt};
  assign o_b = {b_pch, b_ifh, b_iff, b_idh, b_idf, b_jmp, b_jad, b_ack, b_epc, b_abt};

  pipe_ctrl dut (
    .clk(clk), .rstn(rstn),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_rd(id_rs1_rd), .id_rs2_rd(id_rs2_rd), .id_pc(id_pc),
    .ex_rd_addr(ex_rd_addr), .ex_load(ex_load), .ex_div(ex_div), .div_done(div_done),
    .ex_jump(ex_jump), .ex_jump_addr(ex_jump_addr), .irq_req(irq_req),
    .pc_hold(a_pch), .if_id_hold(a_ifh), .if_id_flush(a_iff),
    .id_ex_hold(a_idh), .id_ex_flush(a_idf), .jump_o(a_jmp), .jump_addr_o(a_jad),
    .irq_ack(a_ack), .epc_o(a_epc), .div_abort(a_abt)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(a_sc), .flush_cnt(a_fc)
`endif
  );

  pipe_ctrl #(.DIV_TIMEOUT(8)) dut8 (
    .clk(clk), .rstn(rstn),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_rd(id_rs1_rd), .id_rs2_rd(id_rs2_rd), .id_pc(id_pc),
    .ex_rd_addr(ex_rd_addr), .ex_load(ex_load), .ex_div(ex_div), .div_done(div_done),
    .ex_jump(ex_jump), .ex_jump_addr(ex_jump_addr), .irq_req(irq_req),
    .pc_hold(b_pch), .if_id_hold(b_ifh), .if_id_flush(b_iff),
    .id_ex_hold(b_idh), .id_ex_flush(b_idf), .jump_o(b_jmp), .jump_addr_o(b_jad),
    .irq_ack(b_ack), .epc_o(b_epc), .div_abort(b_abt)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(b_sc), .flush_cnt(b_fc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] cur_epc = 32'h0;
  vec_t        sb_a[$];
  vec_t        sb_b[$];

  function automatic vec_t v_none();
    vec_t v = '0;
    v.epc = cur_epc;
    return v;
  endfunction

  function automatic vec_t v_stall();
    vec_t v = v_none();
    v.pc_hold = 1'b1; v.if_id_hold = 1'b1; v.id_ex_flush = 1'b1;
    return v;
  endfunction

  function automatic vec_t v_jump(input logic [31:0] addr);
    vec_t v = v_none();
    v.jump = 1'b1; v.jaddr = addr; v.if_id_flush = 1'b1; v.id_ex_flush = 1'b1;
    return v;
  endfunction

  function automatic vec_t v_div(input logic abort);
    vec_t v = v_none();
    v.pc_hold = 1'b1; v.if_id_hold = 1'b1; v.id_ex_hold = 1'b1; v.div_abort = abort;
    return v;
  endfunction

  function automatic vec_t v_irq();
    vec_t v = v_jump(32'h0000_0100);
    v.irq_ack = 1'b1;
    return v;
  endfunction

  task automatic clr();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rs1_rd = 1'b0; id_rs2_rd = 1'b0;
    id_pc = 32'h0; ex_rd_addr = 5'd0; ex_load = 1'b0; ex_div = 1'b0; div_done = 1'b0;
    ex_jump = 1'b0; ex_jump_addr = 32'h0; irq_req = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic rd1);
    ex_load = 1'b1; ex_rd_addr = rd; id_rs1_addr = rs1; id_rs1_rd = rd1;
  endtask

  // Inputs are already driven; check this cycle at the falling edge, then cross the rising edge.
  task automatic step(input string tag, input vec_t ea, input vec_t eb);
    vec_t e;
    sb_a.push_back(ea);
    sb_b.push_back(eb);
    @(negedge clk);
    e = sb_a.pop_front();
    vectors++;
    assert (o_a === e) else begin
      miscompares++;
      $error("FAIL %s dut observed=%h expected=%h", tag, o_a, e);
    end
    e = sb_b.pop_front();
    vectors++;
    assert (o_b === e) else begin
      miscompares++;
      $error("FAIL %s dut8 observed=%h expected=%h", tag, o_b, e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    clr();
    ex_jump = 1'b1; ex_jump_addr = 32'h80; irq_req = 1'b1; ex_div = 1'b1;
    #1;
    step("reset", v_none(), v_none());
    rstn = 1'b1;
    clr();
    step("idle", v_none(), v_none());

    // load-use hazards
    load_use(5'd5, 5'd5, 1'b1);
    step("lu_rs1", v_stall(), v_stall());
    clr();
    step("lu_clear", v_none(), v_none());
    load_use(5'd7, 5'd3, 1'b1); id_rs2_rd = 1'b1; id_rs2_addr = 5'd7;
    step("lu_rs2", v_stall(), v_stall());
    clr(); load_use(5'd0, 5'd0, 1'b1);
    step("lu_rd0", v_none(), v_none());
    clr(); load_use(5'd5, 5'd5, 1'b0);
    step("lu_noread", v_none(), v_none());
    clr(); load_use(5'd5, 5'd5, 1'b1); ex_load = 1'b0;
    step("lu_noload", v_none(), v_none());

    // jump over hazard
    clr(); load_use(5'd5, 5'd5, 1'b1); ex_jump = 1'b1; ex_jump_addr = 32'h80;
    step("jump_hazard", v_jump(32'h80), v_jump(32'h80));
    clr();
    step("jump_after", v_none(), v_none());

    // divide completing after 10 cycles; dut8 times out on its 8th cycle
    ex_div = 1'b1;
    step("div_start", v_none(), v_none());
    for (int i = 1; i <= 10; i++) begin
      clr();
      if (i <= 6) begin
        load_use(5'd5, 5'd5, 1'b1); ex_jump = 1'b1; ex_jump_addr = 32'h44; irq_req = 1'b1;
      end
      div_done = (i == 10);
      step("div_wait", v_div(1'b0),
           (i < 8) ? v_div(1'b0) : (i == 8) ? v_div(1'b1) : v_none());
    end
    clr();
    step("div_exit", v_none(), v_none());

    // divide timeout
    ex_div = 1'b1;
    step("to_start", v_none(), v_none());
    clr();
    for (int i = 1; i <= 64; i++) begin
      step("to_wait", (i < 64) ? v_div(1'b0) : v_div(1'b1),
           (i < 8) ? v_div(1'b0) : (i == 8) ? v_div(1'b1) : v_none());
    end
    step("to_exit", v_none(), v_none());

    // div_done coinciding with the dut8 timeout cycle
    ex_div = 1'b1;
    step("dt_start", v_none(), v_none());
    for (int i = 1; i <= 8; i++) begin
      clr();
      div_done = (i == 8);
      step("dt_wait", v_div(1'b0), v_div(1'b0));
    end
    clr();
    step("dt_exit", v_none(), v_none());

    // jump and divide together
    ex_jump = 1'b1; ex_jump_addr = 32'h300; ex_div = 1'b1;
    step("jd_start", v_jump(32'h300), v_jump(32'h300));
    clr();
    step("jd_wait", v_div(1'b0), v_div(1'b0));
    div_done = 1'b1;
    step("jd_done", v_div(1'b0), v_div(1'b0));
    clr();
    step("jd_exit", v_none(), v_none());

    // interrupt
    irq_req = 1'b1; id_pc = 32'h24;
    step("irq_req", v_none(), v_none());
    step("irq_take", v_irq(), v_irq());
    cur_epc = 32'h24;
    clr();
    step("irq_epc", v_none(), v_none());

    // interrupt deferred by hazard, then taken with a jump in the IRQ cycle
    irq_req = 1'b1; load_use(5'd9, 5'd9, 1'b1);
    step("irq_hazard", v_stall(), v_stall());
    clr(); irq_req = 1'b1;
    step("irq_req2", v_none(), v_none());
    clr(); ex_jump = 1'b1; ex_jump_addr = 32'h200; id_pc = 32'h50;
    step("irq_jump", v_irq(), v_irq());
    cur_epc = 32'h200;
    clr();
    step("irq_epc2", v_none(), v_none());

    // interrupt deferred by jump
    irq_req = 1'b1; ex_jump = 1'b1; ex_jump_addr = 32'h90;
    step("irq_vs_jump", v_jump(32'h90), v_jump(32'h90));
    clr();
    step("irq_dropped", v_none(), v_none());

    // reset mid-DIVWAIT
    ex_div = 1'b1;
    step("rd_start", v_none(), v_none());
    clr();
    step("rd_wait", v_div(1'b0), v_div(1'b0));
    rstn = 1'b0;
    cur_epc = 32'h0;
    step("rd_reset", v_none(), v_none());
    rstn = 1'b1;
    step("rd_after", v_none(), v_none());

    // reset mid-IRQ
    irq_req = 1'b1; id_pc = 32'h64;
    step("ri_req", v_none(), v_none());
    clr();
    rstn = 1'b0;
    step("ri_reset", v_none(), v_none());
    rstn = 1'b1;
    step("ri_after", v_none(), v_none());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
